ahb3_spram: RTL and testbench
=============================

# ahb3_spram

AMBA3 AHB-Lite slave that wraps a single-port, word-organised RAM, giving a bus master byte-, halfword- and word-granular read/write access. It sits on the peripheral AHB-Lite fabric of the MPSoC as a scratchpad memory. The companion AHB3 bus functional model drives it in simulation, with the bus `HREADY` tied to this block's `HREADYOUT`.

## Interface
- `MEM_SIZE`, default 256: declared capacity for system address maps; informational only, no decoding.
- `MEM_DEPTH`, default 256: number of XLEN-bit words; power of two.
- `PLEN`, default 16: `HADDR` width.
- `XLEN`, default 32: data width; fixed at 32 for this revision.
- `TECHNOLOGY`, default "GENERIC": "GENERIC" selects an inferred register-array RAM; any other value also uses the generic array.
- `REGISTERED_OUTPUT`, default "NO": "YES" adds an output register and one read wait state.

Ports:
- `HCLK`: in, 1 bit. The single clock.
- `HRESETn`: in, 1 bit. Asynchronous, active-low reset.
- `HSEL`: in, 1 bit. Slave select.
- `HADDR`: in, PLEN bits. Byte address.
- `HWDATA`: in, XLEN bits. Write data, valid in the data phase.
- `HRDATA`: out, XLEN bits. Read data.
- `HWRITE`: in, 1 bit. 1 = write, 0 = read.
- `HSIZE`: in, 3 bits. 0 = byte, 1 = halfword, 2 = word.
- `HBURST`: in, 3 bits. Ignored.
- `HPROT`: in, 4 bits. Ignored.
- `HTRANS`: in, 2 bits. IDLE, BUSY, NONSEQ or SEQ.
- `HMASTLOCK`: in, 1 bit. Ignored.
- `HREADY`: in, 1 bit. Bus ready.
- `HREADYOUT`: out, 1 bit. Slave ready.
- `HRESP`: out, 1 bit. Always 0 (OKAY).

## Operation
- **Transfer accepted** when `HSEL & HREADY & HTRANS[1]` (NONSEQ or SEQ) at a rising `HCLK`.
  - The block then registers the address, `HWRITE` and `HSIZE` for the data phase.
  - IDLE, BUSY, or `HSEL`=0 produce no access; the response is zero-wait OKAY.
- **Word index** = `HADDR[log2(MEM_DEPTH)+1:2]`. Higher address bits are ignored, so accesses wrap modulo MEM_DEPTH words.
- **Byte enables** (little-endian), derived from `HSIZE` and `HADDR[1:0]`:
  - byte: lane `HADDR[1:0]`;
  - halfword: lanes 1:0 if `HADDR[1]`=0, else lanes 3:2;
  - word, or `HSIZE` ≥ 2: all lanes.
  - Misaligned low bits are ignored.
- **Write:**
  - Enabled lanes of `HWDATA` are stored at the registered index at the rising edge ending the data phase.
  - Disabled lanes keep their previous value.
- **Read:**
  - The full word is returned on `HRDATA` irrespective of `HSIZE`; the master selects the lanes.
  - RAM is read using the address-phase address.
- **Read-after-write hazard:** if a read address phase coincides with a write data phase to the same word, `HRDATA` returns the newly written lanes merged with the old ones. No wait state is inserted.
- **Memory contents** are not reset; a read before any write returns undefined data.

## Timing
- **Reset values:** `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0. All registered phase state is cleared, so no pending write exists after reset.
- **Reset mid-transfer:** any in-flight write is discarded.
- **REGISTERED_OUTPUT="NO":**
  - Zero wait states for all transfers.
  - Read data is valid in the data-phase cycle, one cycle after the address phase.
  - `HREADYOUT` is constantly 1 outside reset.
- **REGISTERED_OUTPUT="YES":**
  - Reads take one wait state: `HREADYOUT`=0 for the first data-phase cycle, then 1 with `HRDATA` valid.
  - Writes remain zero-wait.
  - While `HREADYOUT`=0, a new address phase is not accepted, because `HREADY` is low.
- **Back-to-back transfers** (pipelined address/data phases) are sustained at one transfer per cycle in "NO" mode.
- `HRDATA` holds its last value when no read is in its data phase.

## Test plan
- **Reset:** assert `HRESETn`=0 for 32 ns, then release. Expect `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0 throughout reset.
- **Word write/read:** NONSEQ word write 0xDEADBEEF to 0x0010, then read 0x0010. Expect `HRDATA`=0xDEADBEEF in the read data phase, zero waits, `HRESP`=0.
- **Byte/halfword writes:**
  - Write word 0x00000000 to 0x0020.
  - Write byte 0xAA to 0x0021.
  - Write halfword 0x5566 to 0x0022.
  - Read 0x0020. Expect 0x5566AA00.
- **Pipelined write-then-read to the same word:**
  - Sequence: write 0x12345678 to 0x0030, then immediately read 0x0030 with no IDLE cycle between.
  - Expect 0x12345678 (forwarding).
- **Wrap-around:** write 0xCAFEF00D to 0x0400 (word index 256 wraps to 0), then read 0x0000. Expect 0xCAFEF00D.
- **IDLE/BUSY and burst:**
  - IDLE and BUSY transfers with `HWRITE`=1: memory unchanged.
  - INCR4 SEQ write burst 1, 2, 3, 4 at 0x0040–0x004C, read back in burst. Expect 1, 2, 3, 4.
  - With REGISTERED_OUTPUT="YES", expect exactly one `HREADYOUT`=0 cycle per read.

Source files
------------

// File: rtl/ahb3_spram_if.sv
// ahb3_spram_if: AHB-Lite slave port bundle.
// One master drives it and one slave responds.
interface ahb3_spram_if #(
  parameter int PLEN = 16,
  parameter int XLEN = 32
);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HREADYOUT;
  logic            HRESP;

  modport master (
    output HSEL, HADDR, HWDATA, HWRITE,
    output HSIZE, HBURST, HPROT, HTRANS,
    output HMASTLOCK, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWDATA, HWRITE,
    input  HSIZE, HBURST, HPROT, HTRANS,
    input  HMASTLOCK, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3_spram.sv
// ahb3_spram: AHB-Lite slave around a word RAM.
// Byte lanes, write forwarding, optional output reg.
module ahb3_spram #(
  parameter int MEM_SIZE          = 256,
  parameter int MEM_DEPTH         = 256,
  parameter int PLEN              = 16,
  parameter int XLEN              = 32,
  parameter     TECHNOLOGY        = "GENERIC",
  parameter     REGISTERED_OUTPUT = "NO"
) (
  input logic         HCLK,
  input logic         HRESETn,
  ahb3_spram_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam bit REGOUT = (REGISTERED_OUTPUT == "YES");

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t          st, st_nx;
  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic            acc, rd_acc;
  logic [AW-1:0]   a_idx;
  logic            dp_wr;
  logic [AW-1:0]   dp_idx;
  logic [3:0]      dp_be;
  logic            wr_en;
  logic [XLEN-1:0] wr_mask;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] ram_q;
  logic [XLEN-1:0] hrdata_q;
  logic            hready_o;
  logic            ld_out;
  logic            unused_ok;

  function automatic logic [3:0] lanes(
    input logic [2:0] size,
    input logic [1:0] lo
  );
    unique case (1'b1)
      size == 3'd0: lanes = 4'b0001 << lo;
      size == 3'd1: lanes = lo[1] ? 4'b1100 : 4'b0011;
      default:      lanes = 4'b1111;
    endcase
  endfunction

  assign acc    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign rd_acc = acc & ~bus.HWRITE;
  assign a_idx  = bus.HADDR[AW+1:2];
  assign wr_en  = dp_wr & bus.HREADY;

  assign wr_mask = {{8{dp_be[3]}}, {8{dp_be[2]}},
                    {8{dp_be[1]}}, {8{dp_be[0]}}};

  // Read word, merging a same-word write landing this edge
  always_comb begin
    rd_word = mem[a_idx];
    if (wr_en && (dp_idx == a_idx))
      rd_word = (rd_word & ~wr_mask) |
                (bus.HWDATA & wr_mask);
  end

  // Address-phase capture for the write data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_wr  <= 1'b0;
      dp_idx <= '0;
      dp_be  <= '0;
    end else if (bus.HREADY) begin
      dp_wr  <= acc & bus.HWRITE;
      dp_idx <= a_idx;
      dp_be  <= lanes(bus.HSIZE, bus.HADDR[1:0]);
    end
  end

  // RAM array write with per-lane masking
  always_ff @(posedge HCLK) begin
    if (wr_en)
      mem[dp_idx] <= (mem[dp_idx] & ~wr_mask) |
                     (bus.HWDATA & wr_mask);
  end

  // Wait-state state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) st <= S_RUN;
    else          st <= st_nx;
  end

  // Insert one wait state per read when output is registered
  always_comb begin
    st_nx    = st;
    hready_o = 1'b1;
    ld_out   = 1'b0;
    unique case (1'b1)
      st == S_RUN: begin
        if (REGOUT && rd_acc) st_nx = S_WAIT;
      end
      st == S_WAIT: begin
        hready_o = 1'b0;
        ld_out   = 1'b1;
        st_nx    = S_RUN;
      end
      default: st_nx = S_RUN;
    endcase
  end

  // Read data path; HRDATA holds between reads
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ram_q    <= '0;
      hrdata_q <= '0;
    end else begin
      if (REGOUT && rd_acc) ram_q <= rd_word;
      if (!REGOUT && rd_acc) hrdata_q <= rd_word;
      else if (ld_out)       hrdata_q <= ram_q;
    end
  end

  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT = hready_o;
  assign bus.HRESP     = 1'b0;

  assign unused_ok = ^{bus.HBURST, bus.HPROT,
                       bus.HMASTLOCK, bus.HTRANS[0],
                       bus.HADDR, MEM_SIZE[0],
                       TECHNOLOGY == "GENERIC"};
endmodule

// File: tb/tb_ahb3_spram.sv
// tb_ahb3_spram: table, random and corner checks
// for both output modes of ahb3_spram.
module tb_ahb3_spram;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ahb3_spram_if #(.PLEN(16), .XLEN(32)) bus ();
  ahb3_spram_if #(.PLEN(16), .XLEN(32)) ybus ();

  assign bus.HREADY  = bus.HREADYOUT;
  assign ybus.HREADY = ybus.HREADYOUT;

  ahb3_spram #(.REGISTERED_OUTPUT("NO")) dut (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus.slave)
  );

  ahb3_spram #(.REGISTERED_OUTPUT("YES")) ydut (
    .HCLK(clk), .HRESETn(rst_n), .bus(ybus.slave)
  );

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          wr;
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t prev;
  vec_t tbl[$];
  logic [31:0] model [256];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input bit sel, input logic [1:0] tr,
    input bit wr, input logic [2:0] sz,
    input logic [15:0] a, input logic [31:0] d,
    input bit c, input logic [31:0] e);
    vec_t v;
    v.sel = sel; v.trans = tr; v.wr = wr;
    v.size = sz; v.addr = a; v.wdata = d;
    v.chk = c; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] mmask(
    input logic [2:0] s, input logic [15:0] a);
    if (s == 3'd0) return 32'hFF << (8 * a[1:0]);
    if (s == 3'd1) return 32'hFFFF << (16 * a[1]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 4) % 256;
  endfunction

  task automatic step(input vec_t v);
    int i;
    logic [31:0] m;
    bus.HSEL   = v.sel;
    bus.HTRANS = v.trans;
    bus.HWRITE = v.wr;
    bus.HSIZE  = v.size;
    bus.HADDR  = v.addr;
    bus.HWDATA = prev.wdata;
    if (v.sel && v.trans[1] && v.wr) begin
      i = widx(v.addr);
      m = mmask(v.size, v.addr);
      model[i] = (model[i] & ~m) | (v.wdata & m);
    end
    @(negedge clk);
    if (prev.chk) begin
      chk("rdata", bus.HRDATA, prev.exp);
      chk("hready", 32'(bus.HREADYOUT), 32'd1);
      chk("hresp", 32'(bus.HRESP), 32'd0);
    end
    @(posedge clk); #1;
    prev = v;
  endtask

  task automatic yread(input logic [15:0] a,
                       input logic [31:0] e,
                       input string nm);
    int n;
    ybus.HSEL = 1'b1; ybus.HTRANS = 2'd2;
    ybus.HWRITE = 1'b0; ybus.HSIZE = 3'd2;
    ybus.HADDR = a;
    @(posedge clk); #1;
    ybus.HTRANS = 2'd0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ybus.HREADYOUT) break;
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_waits"}, 32'(n), 32'd1);
    chk({nm, "_data"}, ybus.HRDATA, e);
    @(posedge clk); #1;
  endtask

  task automatic ywaddr(input logic [15:0] a);
    ybus.HSEL = 1'b1; ybus.HTRANS = 2'd2;
    ybus.HWRITE = 1'b1; ybus.HSIZE = 3'd2;
    ybus.HADDR = a;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vec_t idle;
    bus.HSEL = 0; bus.HTRANS = 0; bus.HWRITE = 0;
    bus.HSIZE = 0; bus.HADDR = 0; bus.HWDATA = 0;
    bus.HBURST = 3'd3; bus.HPROT = 0;
    bus.HMASTLOCK = 0;
    ybus.HSEL = 0; ybus.HTRANS = 0; ybus.HWRITE = 0;
    ybus.HSIZE = 0; ybus.HADDR = 0; ybus.HWDATA = 0;
    ybus.HBURST = 0; ybus.HPROT = 0;
    ybus.HMASTLOCK = 0;
    idle = mk(0, 0, 0, 2, 0, 0, 0, 0);
    prev = idle;
    for (int i = 0; i < 256; i++) model[i] = '0;

    #1 rst_n = 1'b0;
    #6;
    chk("rst_hready", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(bus.HRESP), 32'd0);
    chk("rst_hrdata", bus.HRDATA, 32'd0);
    #20;
    chk("rst_hrdata2", bus.HRDATA, 32'd0);
    chk("rst_yhready", 32'(ybus.HREADYOUT), 32'd1);
    chk("rst_yhrdata", ybus.HRDATA, 32'd0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back(mk(1, 2, 1, 2, 16'h0010, 32'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, 2, 0, 2, 16'h0010, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(1, 2, 1, 2, 16'h0020, 32'h0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 0, 16'h0021, 32'h1111AA22, 0, 0));
    tbl.push_back(mk(1, 2, 1, 1, 16'h0022, 32'h55663344, 0, 0));
    tbl.push_back(mk(1, 2, 0, 2, 16'h0020, 0, 1, 32'h5566AA00));
    tbl.push_back(mk(1, 2, 1, 2, 16'h0030, 32'h12345678, 0, 0));
    tbl.push_back(mk(1, 2, 0, 2, 16'h0030, 0, 1, 32'h12345678));
    tbl.push_back(mk(1, 2, 1, 2, 16'h0400, 32'hCAFEF00D, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 2, 16'h0000, 0, 1, 32'hCAFEF00D));
    tbl.push_back(mk(1, 2, 1, 2, 16'h0040, 32'd1, 0, 0));
    tbl.push_back(mk(1, 3, 1, 2, 16'h0044, 32'd2, 0, 0));
    tbl.push_back(mk(1, 3, 1, 2, 16'h0048, 32'd3, 0, 0));
    tbl.push_back(mk(1, 3, 1, 2, 16'h004C, 32'd4, 0, 0));
    tbl.push_back(mk(1, 0, 1, 2, 16'h0040, 32'hBAD0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 2, 16'h0044, 32'hBAD1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 2, 16'h0048, 32'hBAD2, 0, 0));
    tbl.push_back(mk(1, 2, 0, 2, 16'h0040, 0, 1, 32'd1));
    tbl.push_back(mk(1, 3, 0, 2, 16'h0044, 0, 1, 32'd2));
    tbl.push_back(mk(1, 3, 0, 2, 16'h0048, 0, 1, 32'd3));
    tbl.push_back(mk(1, 3, 0, 2, 16'h004C, 0, 1, 32'd4));
    tbl.push_back(mk(1, 2, 1, 2, 16'h0050, 32'h11111111, 0, 0));
    tbl.push_back(idle);
    foreach (tbl[i]) step(tbl[i]);

    bus.HSEL = 1; bus.HTRANS = 2'd2; bus.HWRITE = 1;
    bus.HSIZE = 3'd2; bus.HADDR = 16'h0050;
    bus.HWDATA = 0;
    @(posedge clk); #1;
    bus.HTRANS = 2'd0;
    bus.HWDATA = 32'h22222222;
    rst_n = 1'b0;
    #2;
    chk("midrst_hrdata", bus.HRDATA, 32'd0);
    chk("midrst_hready", 32'(bus.HREADYOUT), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    prev = idle;
    step(mk(1, 2, 0, 2, 16'h0050, 0, 1, 32'h11111111));
    step(idle);

    for (int i = 0; i < 256; i++)
      step(mk(1, 2, 1, 2, 16'(i * 4), $urandom, 0, 0));
    step(idle);

    for (int n = 0; n < 500; n++) begin
      v.sel   = ($urandom_range(0, 7) != 0);
      v.trans = 2'($urandom_range(0, 3));
      v.wr    = 1'($urandom_range(0, 1));
      v.size  = 3'($urandom_range(0, 3));
      v.addr  = 16'(($urandom_range(0, 63) << 10) |
                    ($urandom_range(0, 7) << 2) |
                    $urandom_range(0, 3));
      v.wdata = $urandom;
      v.chk   = v.sel && v.trans[1] && !v.wr;
      v.exp   = model[widx(v.addr)];
      step(v);
    end
    step(idle);

    ywaddr(16'h0010);
    ybus.HTRANS = 2'd0;
    ybus.HWDATA = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("y_wr_ready", 32'(ybus.HREADYOUT), 32'd1);
    @(posedge clk); #1;
    yread(16'h0010, 32'hA5A5_5A5A, "y_rd");
    ywaddr(16'h0030);
    ybus.HWDATA = 32'h0BADF00D;
    yread(16'h0030, 32'h0BADF00D, "y_fwd");
    yread(16'h0010, 32'hA5A5_5A5A, "y_rd2");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
